// File: rtl/order_manager_if.sv
// Bundles the game-state input, the delivery handshake and the order/score outputs
// that connect the order manager to its host.
interface order_manager_if;
   logic [2:0]      game_state;
   logic            deliver_valid;
   logic [1:0]      deliver_dish;
   logic [3:0]      orders;
   logic [3:0][1:0] order_dishes;
   logic [3:0][4:0] order_times;
   logic [7:0]      time_left;
   logic [9:0]      point_total;
   logic            deliver_accept;
   logic            deliver_reject;
   logic            game_over;

   modport master (
      output game_state, deliver_valid, deliver_dish,
      input  orders, order_dishes, order_times, time_left, point_total,
             deliver_accept, deliver_reject, game_over
   );

   modport slave (
      input  game_state, deliver_valid, deliver_dish,
      output orders, order_dishes, order_times, time_left, point_total,
             deliver_accept, deliver_reject, game_over
   );
endinterface

// File: rtl/order_manager.sv
// Order manager for a timed cooking round: spawns up to four orders, ages them,
// scores deliveries and expiries, and runs the round clock.
//
// state    | meaning
// ST_IDLE  | after reset, waiting for the first START
// ST_RUN   | round armed; counts while game_state is PLAY
// ST_OVER  | time ran out; everything frozen until the next START
module order_manager #(
   parameter int unsigned TICKS_PER_SEC  = 65000000,
   parameter int unsigned GAME_TIME      = 180,
   parameter int unsigned ORDER_TIME     = 30,
   parameter int unsigned SPAWN_INTERVAL = 10,
   parameter int unsigned ORDER_POINTS   = 20,
   parameter int unsigned EXPIRE_PENALTY = 10
) (
   input logic            clock_i,
   input logic            reset_i,
   order_manager_if.slave bus
);
   localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int SW = $clog2(SPAWN_INTERVAL + 1);
   localparam logic [2:0] GS_START = 3'd1;
   localparam logic [2:0] GS_PLAY  = 3'd2;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_OVER} state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tick_q, tick_d;
   logic [SW-1:0]   spawn_cnt_q, spawn_cnt_d;
   logic [7:0]      time_left_q, time_left_d;
   logic [9:0]      points_q, points_d;
   logic [3:0]      orders_q, orders_d;
   logic [3:0][1:0] dishes_q, dishes_d;
   logic [3:0][4:0] otimes_q, otimes_d;
   logic            accept_q, accept_d;
   logic            reject_q, reject_d;
   logic [15:0]     lfsr_q, lfsr_d;

   logic            sec_tick;
   logic            hit;
   logic [1:0]      hit_idx;
   logic            free_found;
   logic [1:0]      free_idx;
   logic [SW-1:0]   spawn_inc;
   logic [2:0]      expire_cnt;
   logic [11:0]     award;
   logic [11:0]     penalty;
   logic [11:0]     score;

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q     <= ST_IDLE;
         tick_q      <= '0;
         spawn_cnt_q <= '0;
         time_left_q <= '0;
         points_q    <= '0;
         orders_q    <= '0;
         dishes_q    <= '0;
         otimes_q    <= '0;
         accept_q    <= 1'b0;
         reject_q    <= 1'b0;
         lfsr_q      <= 16'hACE1;
      end else begin
         state_q     <= state_d;
         tick_q      <= tick_d;
         spawn_cnt_q <= spawn_cnt_d;
         time_left_q <= time_left_d;
         points_q    <= points_d;
         orders_q    <= orders_d;
         dishes_q    <= dishes_d;
         otimes_q    <= otimes_d;
         accept_q    <= accept_d;
         reject_q    <= reject_d;
         lfsr_q      <= lfsr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      tick_d      = tick_q;
      spawn_cnt_d = spawn_cnt_q;
      time_left_d = time_left_q;
      points_d    = points_q;
      orders_d    = orders_q;
      dishes_d    = dishes_q;
      otimes_d    = otimes_q;
      accept_d    = 1'b0;
      reject_d    = 1'b0;
      lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      sec_tick    = 1'b0;
      hit         = 1'b0;
      hit_idx     = '0;
      free_found  = 1'b0;
      free_idx    = '0;
      spawn_inc   = spawn_cnt_q + 1'b1;
      expire_cnt  = '0;
      award       = '0;
      penalty     = '0;
      score       = '0;

      if (bus.game_state == GS_START) begin
         state_d     = ST_RUN;
         tick_d      = '0;
         spawn_cnt_d = '0;
         time_left_d = 8'(GAME_TIME);
         points_d    = '0;
         orders_d    = '0;
         dishes_d    = '0;
         otimes_d    = '0;
      end else if (state_q == ST_RUN && bus.game_state == GS_PLAY) begin
         sec_tick = (tick_q == TW'(TICKS_PER_SEC - 1));
         tick_d   = sec_tick ? '0 : tick_q + 1'b1;

         // Matching and award use the slot contents from the start of the cycle.
         if (bus.deliver_valid) begin
            for (int i = 3; i >= 0; i--) begin
               if (orders_q[i] && dishes_q[i] == bus.deliver_dish) begin
                  hit     = 1'b1;
                  hit_idx = 2'(i);
               end
            end
            if (hit) begin
               accept_d = 1'b1;
               award    = 12'(ORDER_POINTS) + 12'(otimes_q[hit_idx]);
            end else begin
               reject_d = 1'b1;
            end
         end

         if (sec_tick) begin
            time_left_d = time_left_q - 8'd1;
            if (time_left_q <= 8'd1) begin
               time_left_d = '0;
               state_d     = ST_OVER;
            end
            for (int i = 0; i < 4; i++) begin
               if (orders_q[i] && !(hit && hit_idx == 2'(i))) begin
                  if (otimes_q[i] == 5'd1) begin
                     orders_d[i] = 1'b0;
                     otimes_d[i] = '0;
                     expire_cnt  = expire_cnt + 3'd1;
                  end else begin
                     otimes_d[i] = otimes_q[i] - 5'd1;
                  end
               end
            end
            for (int i = 3; i >= 0; i--) begin
               if (!orders_q[i]) begin
                  free_found = 1'b1;
                  free_idx   = 2'(i);
               end
            end
            spawn_cnt_d = (spawn_inc == SW'(SPAWN_INTERVAL)) ? '0 : spawn_inc;
            if ((spawn_inc == SW'(SPAWN_INTERVAL) || orders_q == 4'd0) && free_found) begin
               orders_d[free_idx] = 1'b1;
               otimes_d[free_idx] = 5'(ORDER_TIME);
               dishes_d[free_idx] = lfsr_q[1:0];
            end
         end

         if (hit) begin
            orders_d[hit_idx] = 1'b0;
            otimes_d[hit_idx] = '0;
         end

         // Two's-complement 12-bit sum; bit 11 set means the score went negative.
         penalty = 12'(expire_cnt) * 12'(EXPIRE_PENALTY);
         score   = 12'(points_q) + award - penalty;
         if (score[11])
            points_d = '0;
         else if (score > 12'd999)
            points_d = 10'd999;
         else
            points_d = score[9:0];
      end
   end

   assign bus.orders         = orders_q;
   assign bus.order_dishes   = dishes_q;
   assign bus.order_times    = otimes_q;
   assign bus.time_left      = time_left_q;
   assign bus.point_total    = points_q;
   assign bus.deliver_accept = accept_q;
   assign bus.deliver_reject = reject_q;
   assign bus.game_over      = (state_q == ST_OVER);
endmodule

// File: tb/tb_order_manager.sv
// Self-checking bench for order_manager: directed round scenarios plus randomized
// play compared every cycle against a behavioural model of the game rules.
module tb_order_manager;
   localparam int TPS = 4;
   localparam int GT  = 5;
   localparam int OT  = 3;
   localparam int SI  = 2;
   localparam int OP  = 20;
   localparam int EP  = 10;
   localparam logic [2:0] GS_WELCOME = 3'd0;
   localparam logic [2:0] GS_START   = 3'd1;
   localparam logic [2:0] GS_PLAY    = 3'd2;
   localparam logic [2:0] GS_PAUSE   = 3'd3;
   localparam logic [2:0] GS_FINISH  = 3'd4;

   logic clk;
   logic rst_n;
   int   n_total;
   int   n_pass;

   order_manager_if bus();

   order_manager #(
      .TICKS_PER_SEC(TPS), .GAME_TIME(GT), .ORDER_TIME(OT),
      .SPAWN_INTERVAL(SI), .ORDER_POINTS(OP), .EXPIRE_PENALTY(EP)
   ) dut (
      .clock_i(clk),
      .reset_i(rst_n),
      .bus    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          m_armed, m_over, m_tick, m_spawn, m_time, m_pts, m_acc, m_rej;
   int          m_act[4], m_dish[4], m_otime[4];
   logic [15:0] m_lfsr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp)
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      else
         n_pass++;
   endtask

   task automatic model_reset();
      m_armed = 0; m_over = 0; m_tick = 0; m_spawn = 0; m_time = 0; m_pts = 0;
      m_acc = 0; m_rej = 0; m_lfsr = 16'hACE1;
      for (int i = 0; i < 4; i++) begin
         m_act[i] = 0; m_dish[i] = 0; m_otime[i] = 0;
      end
   endtask

   task automatic model_step(input logic [2:0] gs, input logic dv, input int dd);
      int hit, award, pen, busy, free_slot, score;
      logic [15:0] old_l;
      old_l  = m_lfsr;
      m_lfsr = {old_l[14:0], old_l[15] ^ old_l[13] ^ old_l[12] ^ old_l[10]};
      m_acc  = 0;
      m_rej  = 0;
      if (gs == GS_START) begin
         m_armed = 1; m_over = 0; m_tick = 0; m_spawn = 0; m_time = GT; m_pts = 0;
         for (int i = 0; i < 4; i++) begin
            m_act[i] = 0; m_dish[i] = 0; m_otime[i] = 0;
         end
         return;
      end
      if (gs != GS_PLAY || m_armed == 0 || m_over != 0) return;
      hit = -1; award = 0; pen = 0; busy = 0;
      for (int i = 0; i < 4; i++) busy += m_act[i];
      if (dv) begin
         for (int i = 3; i >= 0; i--)
            if (m_act[i] != 0 && m_dish[i] == dd) hit = i;
         if (hit >= 0) begin
            award = OP + m_otime[hit];
            m_acc = 1;
         end else begin
            m_rej = 1;
         end
      end
      if (m_tick == TPS - 1) begin
         m_tick = 0;
         free_slot = -1;
         for (int i = 3; i >= 0; i--)
            if (m_act[i] == 0) free_slot = i;
         for (int i = 0; i < 4; i++) begin
            if (m_act[i] != 0 && i != hit) begin
               if (m_otime[i] == 1) begin
                  m_act[i] = 0; m_otime[i] = 0; pen += EP;
               end else begin
                  m_otime[i]--;
               end
            end
         end
         m_time--;
         if (m_time <= 0) begin
            m_time = 0; m_over = 1;
         end
         m_spawn++;
         if ((m_spawn == SI || busy == 0) && free_slot >= 0) begin
            m_act[free_slot] = 1;
            m_otime[free_slot] = OT;
            m_dish[free_slot] = int'(old_l[1:0]);
         end
         if (m_spawn == SI) m_spawn = 0;
      end else begin
         m_tick++;
      end
      if (hit >= 0) begin
         m_act[hit] = 0; m_otime[hit] = 0;
      end
      score = m_pts + award - pen;
      m_pts = (score < 0) ? 0 : (score > 999) ? 999 : score;
   endtask

   task automatic compare_all();
      logic [3:0]      eo;
      logic [3:0][1:0] ed;
      logic [3:0][4:0] et;
      for (int i = 0; i < 4; i++) begin
         eo[i] = (m_act[i] != 0);
         ed[i] = 2'(m_dish[i]);
         et[i] = 5'(m_otime[i]);
      end
      check("orders", bus.orders, eo);
      check("order_dishes", bus.order_dishes, ed);
      check("order_times", bus.order_times, et);
      check("time_left", bus.time_left, m_time);
      check("point_total", bus.point_total, m_pts);
      check("deliver_accept", bus.deliver_accept, m_acc);
      check("deliver_reject", bus.deliver_reject, m_rej);
      check("game_over", bus.game_over, m_over);
   endtask

   task automatic run_cycle(input logic [2:0] gs, input logic dv, input logic [1:0] dd);
      @(negedge clk);
      bus.game_state    = gs;
      bus.deliver_valid = dv;
      bus.deliver_dish  = dd;
      @(posedge clk);
      model_step(gs, dv, int'(dd));
      #1;
      compare_all();
   endtask

   initial begin
      int d, r;
      logic [2:0] gs;
      n_total = 0;
      n_pass  = 0;
      rst_n = 1'b0;
      bus.game_state    = GS_WELCOME;
      bus.deliver_valid = 1'b0;
      bus.deliver_dish  = 2'd0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      compare_all();
      rst_n = 1'b1;

      // Before any START the block stays idle even in PLAY.
      repeat (6) run_cycle(GS_PLAY, 1'b1, 2'd0);
      check("idle_time_left", bus.time_left, 0);

      // Round 1: first spawn, accept, reject, expiry with score, game over.
      run_cycle(GS_START, 1'b0, 2'd0);
      check("start_time_left", bus.time_left, GT);
      repeat (3) run_cycle(GS_PLAY, 1'b0, 2'd0);
      check("pre_tick_orders", bus.orders, 0);
      run_cycle(GS_PLAY, 1'b0, 2'd0);
      check("spawn_orders", bus.orders, 4'b0001);
      check("spawn_otime0", bus.order_times[0], OT);
      check("tick1_time_left", bus.time_left, GT - 1);
      repeat (4) run_cycle(GS_PLAY, 1'b0, 2'd0);
      d = m_dish[0];
      run_cycle(GS_PLAY, 1'b1, 2'(d));
      check("accept_pulse", bus.deliver_accept, 1);
      check("accept_points", bus.point_total, 22);
      check("accept_clears", bus.orders[0], 0);
      d = (m_dish[1] + 1) % 4;
      run_cycle(GS_PLAY, 1'b1, 2'(d));
      check("reject_pulse", bus.deliver_reject, 1);
      check("reject_points", bus.point_total, 22);
      repeat (10) run_cycle(GS_PLAY, 1'b0, 2'd0);
      check("over_flag", bus.game_over, 1);
      check("over_time_left", bus.time_left, 0);
      check("expire_points", bus.point_total, 12);
      for (int i = 0; i < 12; i++) run_cycle(GS_PLAY, 1'b1, 2'(i % 4));
      check("over_points_hold", bus.point_total, 12);

      // Round 2: expiry from zero score saturates; spawn skips the slot cleared that tick.
      run_cycle(GS_START, 1'b0, 2'd0);
      repeat (16) run_cycle(GS_PLAY, 1'b0, 2'd0);
      check("sat_points", bus.point_total, 0);
      check("sat_slot0_clear", bus.orders[0], 0);
      check("refill_slot2", bus.orders[2], 1);

      // Round 3: delivery on the tick where slot 0 would expire.
      run_cycle(GS_START, 1'b0, 2'd0);
      repeat (15) run_cycle(GS_PLAY, 1'b0, 2'd0);
      d = m_dish[0];
      run_cycle(GS_PLAY, 1'b1, 2'(d));
      check("race_accept", bus.deliver_accept, 1);
      check("race_points", bus.point_total, OP + 1);

      // Round 4: PAUSE freezes everything for 100 cycles.
      run_cycle(GS_START, 1'b0, 2'd0);
      repeat (6) run_cycle(GS_PLAY, 1'b0, 2'd0);
      for (int i = 0; i < 100; i++)
         run_cycle(GS_PAUSE, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      check("pause_time_left", bus.time_left, GT - 1);
      check("pause_otime0", bus.order_times[0], OT);
      repeat (2) run_cycle(GS_PLAY, 1'b0, 2'd0);
      check("resume_tick", bus.time_left, GT - 2);

      // Asynchronous reset between edges mid-PLAY.
      run_cycle(GS_PLAY, 1'b0, 2'd0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Randomized play against the model.
      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 99);
         if (r < 3)       gs = GS_START;
         else if (r < 83) gs = GS_PLAY;
         else if (r < 93) gs = GS_PAUSE;
         else if (r < 96) gs = GS_WELCOME;
         else if (r < 98) gs = GS_FINISH;
         else             gs = 3'($urandom_range(5, 7));
         run_cycle(gs, ($urandom_range(0, 9) < 4), 2'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
